// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides,
// iterative shift-add multiply and restoring divide, registered results/flags.
// Optional feature macro: ALU_DIV_EN builds the divider and DIV state; when
// undefined, opcode 011 completes in one cycle with f=0, x=0, e=1.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle (ALU_DIV_EN only)
// DONE  | out_valid=1, result held until out_ready

module alu_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int HIGH       = DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            oc,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] f,
    output logic [DATA_WIDTH-1:0] x,
    output logic                  z,
    output logic                  n,
    output logic                  c,
    output logic                  v,
    output logic                  e
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // hi/lo form the double-width working register: product {hi,lo} for MUL,
    // {remainder, dividend/quotient} for DIV. md holds multiplicand or divisor.
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, md_q, md_d;
    logic [DATA_WIDTH-1:0] f_q, x_q;
    logic                  z_q, n_q, c_q, v_q, e_q;

    logic                  load;
    logic [DATA_WIDTH-1:0] res_f, res_x;
    logic                  res_c, res_v, res_e;
    logic [DATA_WIDTH:0]   sum, diff;
`ifdef ALU_DIV_EN
    logic [DATA_WIDTH:0]   trial;
`endif

    // Next-state, iteration step and result selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        md_d    = md_q;
        load    = 1'b0;
        res_f   = '0;
        res_x   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_e   = 1'b0;
        sum     = '0;
        diff    = '0;
`ifdef ALU_DIV_EN
        trial   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    case (oc)
                        OC_ADD: begin
                            sum   = {1'b0, a} + {1'b0, b};
                            res_f = sum[HIGH:0];
                            res_c = sum[DATA_WIDTH];
                            res_v = (a[HIGH] == b[HIGH]) && (sum[HIGH] != a[HIGH]);
                        end
                        OC_SUB: begin
                            diff  = {1'b0, a} - {1'b0, b};
                            res_f = diff[HIGH:0];
                            res_c = diff[DATA_WIDTH];
                            res_v = (a[HIGH] != b[HIGH]) && (diff[HIGH] != a[HIGH]);
                        end
                        OC_MUL: begin
                            load    = 1'b0;
                            md_d    = a;
                            lo_d    = b;
                            hi_d    = '0;
                            cnt_d   = CNT_LOAD;
                            state_d = S_MUL;
                        end
                        OC_DIV: begin
`ifdef ALU_DIV_EN
                            if (b == '0) begin
                                res_f = '1;
                                res_x = a;
                                res_e = 1'b1;
                            end else begin
                                load    = 1'b0;
                                md_d    = b;
                                lo_d    = a;
                                hi_d    = '0;
                                cnt_d   = CNT_LOAD;
                                state_d = S_DIV;
                            end
`else
                            res_e = 1'b1;
`endif
                        end
                        OC_NOT: res_f = ~a;
                        OC_XOR: res_f = a ^ b;
                        OC_OR:  res_f = a | b;
                        OC_AND: res_f = a & b;
                    endcase
                end
            end
            S_MUL: begin
                sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
                hi_d = sum[DATA_WIDTH:1];
                lo_d = {sum[0], lo_q[HIGH:1]};
                if (cnt_q == '0) begin
                    load  = 1'b1;
                    res_f = lo_d;
                    res_x = hi_d;
                    res_v = |hi_d;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                // Borrow out of the trial subtraction means the divisor did not fit.
                trial = {hi_q, lo_q[HIGH]} - {1'b0, md_q};
                hi_d  = trial[DATA_WIDTH] ? {hi_q[HIGH-1:0], lo_q[HIGH]} : trial[HIGH:0];
                lo_d  = {lo_q[HIGH-1:0], ~trial[DATA_WIDTH]};
                if (cnt_q == '0) begin
                    load  = 1'b1;
                    res_f = lo_d;
                    res_x = hi_d;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load) state_d = S_DONE;
    end

    // State, working registers and output registers; results load only on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            md_q    <= '0;
            f_q     <= '0;
            x_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            md_q    <= md_d;
            if (load) begin
                f_q <= res_f;
                x_q <= res_x;
                z_q <= (res_f == '0);
                n_q <= res_f[HIGH];
                c_q <= res_c;
                v_q <= res_v;
                e_q <= res_e;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign f = f_q;
    assign x = x_q;
    assign z = z_q;
    assign n = n_q;
    assign c = c_q;
    assign v = v_q;
    assign e = e_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: the driver pushes expected results from a
// plain-arithmetic reference model; a negedge monitor compares on out_valid.
`timescale 1ns/1ps
module tb_alu_mc;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0] oc;
    logic [W-1:0] a, b, f, x;
    logic z, n, c, v, e;

    alu_mc #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .oc(oc), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .x(x), .z(z), .n(n), .c(c), .v(v), .e(e)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] f;
        logic [W-1:0] x;
        logic z, n, c, v, e;
    } res_t;

    typedef struct {
        res_t r;
        int   lat;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   or_mode = 0;
    logic prev_ov = 1'b0;
    logic hs_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic res_t mk(input logic [W-1:0] ff, input logic [W-1:0] xx,
                                input logic zz, nn, cc, vv, ee);
        res_t r;
        r = {ff, xx, zz, nn, cc, vv, ee};
        return r;
    endfunction

    // Reference model: integer arithmetic on unsigned and signed views of the operands.
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        res_t r;
        int unsigned ua, ub;
        int sa, sbv;
        longint unsigned p;
        r = '0;
        ua = aa;
        ub = bb;
        sa = $signed(aa);
        sbv = $signed(bb);
        case (o)
            3'd0: begin
                r.f = 16'(ua + ub);
                r.c = (ua + ub) > 65535;
                r.v = (sa + sbv > 32767) || (sa + sbv < -32768);
            end
            3'd1: begin
                r.f = 16'(ua - ub);
                r.c = ua < ub;
                r.v = (sa - sbv > 32767) || (sa - sbv < -32768);
            end
            3'd2: begin
                p = longint'(ua) * longint'(ub);
                r.f = p[15:0];
                r.x = p[31:16];
                r.v = (r.x != 0);
            end
            3'd3: begin
`ifdef ALU_DIV_EN
                if (ub == 0) begin
                    r.f = 16'hFFFF;
                    r.x = aa;
                    r.e = 1'b1;
                end else begin
                    r.f = 16'(ua / ub);
                    r.x = 16'(ua % ub);
                end
`else
                r.e = 1'b1;
`endif
            end
            3'd4: r.f = ~aa;
            3'd5: r.f = aa ^ bb;
            3'd6: r.f = aa | bb;
            default: r.f = aa & bb;
        endcase
        r.z = (r.f == 0);
        r.n = r.f[15];
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [W-1:0] bb);
        if (o == 3'd2) return W + 1;
`ifdef ALU_DIV_EN
        if (o == 3'd3 && bb != 0) return W + 1;
`endif
        return 1;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Consumer side: random backpressure, or forced low/high for directed cases.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0: out_ready = ($urandom_range(0, 3) != 0);
                1: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every cycle with out_valid the held result must match the scoreboard head.
    always @(negedge clk) begin
        exp_t ex;
        res_t act;
        if (rst) begin
            prev_ov = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("post_hs_out_valid", out_valid, 1'b0);
                chk("post_hs_in_ready", in_ready, 1'b1);
            end
            hs_prev = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1'b1, 1'b0);
                end else begin
                    ex = sb[0];
                    act = {f, x, z, n, c, v, e};
                    if (!prev_ov) chk("latency", cyc + 1 - ex.acc, ex.lat);
                    chk("result", act, ex.r);
                    chk("done_in_ready", in_ready, 1'b0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input res_t r, input int lat);
        exp_t ex;
        int g;
        g = 0;
        @(posedge clk); #1;
        while (!in_ready && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 1'b0, 1'b1);
            return;
        end
        in_valid = 1'b1;
        oc = o;
        a = aa;
        b = bb;
        ex.r = r;
        ex.lat = lat;
        ex.acc = cyc + 1;
        sb.push_back(ex);
        @(posedge clk); #1;
        in_valid = 1'b0;
        oc = 3'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] o;
        logic [W-1:0] ra, rb;
        int g;
        rst = 1'b1;
        in_valid = 1'b0;
        oc = 3'd0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", {in_ready, out_valid, f, x, z, n, c, v, e}, {1'b1, 1'b0, 37'h0});

        issue(3'd0, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0000, 1, 0, 1, 0, 0), 1); drain();
        issue(3'd1, 16'h8000, 16'h0001, mk(16'h7FFF, 16'h0000, 0, 0, 0, 1, 0), 1); drain();
        issue(3'd1, 16'h0001, 16'h0002, mk(16'hFFFF, 16'h0000, 0, 1, 1, 0, 0), 1); drain();

        issue(3'd2, 16'h1234, 16'h0100, mk(16'h3400, 16'h0012, 0, 0, 0, 1, 0), W + 1);
        g = 0;
        while (!out_valid && g < 40) begin
            chk("mul_busy_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            g++;
        end
        drain();

`ifdef ALU_DIV_EN
        issue(3'd3, 16'd100, 16'd7, mk(16'h000E, 16'h0002, 0, 0, 0, 0, 0), W + 1); drain();
        issue(3'd3, 16'd5, 16'd0, mk(16'hFFFF, 16'h0005, 0, 1, 0, 0, 1), 1); drain();
`else
        issue(3'd3, 16'd100, 16'd7, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 1), 1); drain();
        issue(3'd3, 16'd5, 16'd0, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 1), 1); drain();
`endif
        issue(3'd4, 16'h00FF, 16'h1234, mk(16'hFF00, 16'h0000, 0, 1, 0, 0, 0), 1); drain();
        issue(3'd5, 16'hA5A5, 16'h0FF0, mk(16'hAA55, 16'h0000, 0, 1, 0, 0, 0), 1); drain();
        issue(3'd6, 16'h0A00, 16'h0050, mk(16'h0A50, 16'h0000, 0, 0, 0, 0, 0), 1); drain();
        issue(3'd7, 16'hF0F0, 16'h0F0F, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 0), 1); drain();

        // Backpressure: hold the result for five cycles while poking in_valid.
        or_mode = 1;
        issue(3'd0, 16'h1111, 16'h2222, mk(16'h3333, 16'h0000, 0, 0, 0, 0, 0), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            oc = 3'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        or_mode = 2;
        drain();
        or_mode = 0;

        // Reset in the middle of a multiply discards it.
        issue(3'd0, 16'h0001, 16'h0001, mk(16'h0002, 16'h0000, 0, 0, 0, 0, 0), 1); drain();
        issue(3'd2, 16'hFFFF, 16'hFFFF, model(3'd2, 16'hFFFF, 16'hFFFF), W + 1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_mul_reset", {in_ready, out_valid, f, x, z, n, c, v, e}, {1'b1, 1'b0, 37'h0});
        issue(3'd0, 16'd2, 16'd3, mk(16'h0005, 16'h0000, 0, 0, 0, 0, 0), 1); drain();

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            ra = rnd_op();
            rb = rnd_op();
            issue(o, ra, rb, model(o, ra, rb), lat_of(o, rb));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the datapath ALU. Same 3-bit opcode map. Adds:
- registered outputs;
- valid/ready handshakes on both sides;
- iterative multiply and divide with full-width high-half and remainder results;
- status flags.

It sits between operand fetch and writeback, which may stall it.

## Interface
- `DATA_WIDTH`, 16: operand/result width, ≥ 2.
- `HIGH`, `DATA_WIDTH-1`: MSB index, derived; do not override.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands/opcode valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `oc`  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 NOT(a), 101 XOR, 110 OR, 111 AND.
- `a`, `b`  in  DATA_WIDTH  unsigned operands.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `f`  out  DATA_WIDTH  primary result; low half of product; quotient.
- `x`  out  DATA_WIDTH  extension result: MUL high half, DIV remainder, 0 for all other ops.
- `z`, `n`  out  1  `f == 0`; `f[HIGH]`.
- `c`  out  1  ADD carry-out; SUB borrow (`a < b`); 0 for all other ops.
- `v`  out  1  ADD/SUB two's-complement overflow; MUL `x != 0`; 0 for all other ops.
- `e`  out  1  divide by zero; also unsupported DIV (see Configuration).

## Operation
- States:
  - IDLE: `in_ready=1`.
  - MUL: shift-add iteration.
  - DIV: restoring iteration.
  - DONE: `out_valid=1`.
- Accept occurs when `in_valid && in_ready` at a rising edge. At accept, `oc`/`a`/`b` are latched and later input changes are ignored.
- IDLE → DONE on accept of ADD, SUB, NOT, XOR, OR, AND. Result and flags are computed from the latched operands and registered.
- IDLE → DONE on accept of DIV with `b == 0`. Result: `f` = all ones, `x = a`, `e=1`.
- IDLE → MUL/DIV on other MUL/DIV accepts. The iteration counter loads `DATA_WIDTH-1`.
- MUL/DIV step:
  - one bit per cycle;
  - exits to DONE after the step with counter 0, i.e. exactly `DATA_WIDTH` cycles in state;
  - the 2·DATA_WIDTH-bit product is exact, as are quotient and remainder.
- DONE → IDLE when `out_ready=1`. No new accept occurs in the handshake cycle itself.
- In DONE, `f`, `x` and the flags stay stable while `out_valid && !out_ready`.
- Flags not defined for an op are 0. `z` and `n` are always derived from `f`.
- Reset: state IDLE, counter 0, all datapath registers 0.
  - Outputs after reset: `in_ready=1`, `out_valid=0`, `f=x=0`, `z=n=c=v=e=0`.
- Reset mid-MUL/DIV or in DONE discards the operation. Reset wins over any simultaneous handshake.

## Timing
- Latency is counted from the accept edge to the first edge with `out_valid=1` sampled.
  - Single-cycle ops and DIV by zero: 1 cycle.
  - MUL and DIV: `DATA_WIDTH+1` cycles (17 at default).
- Throughput, zero backpressure:
  - single-cycle ops: one per 2 cycles;
  - MUL/DIV: one per `DATA_WIDTH+2` cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `ALU_DIV_EN` defined: divider datapath and DIV state are built as above.
- `ALU_DIV_EN` undefined:
  - no divider logic and no DIV state;
  - opcode 011 completes in 1 cycle with `f=0`, `x=0`, `e=1`;
  - all other ops are unchanged.

## Test plan
All values at `DATA_WIDTH=16`.
- ADD a=0xFFFF, b=0x0001 -> 1 cycle later: `f=0x0000`, `z=1`, `c=1`, `v=0`, `x=0`.
- SUB a=0x8000, b=0x0001 -> `f=0x7FFF`, `v=1`, `c=0`, `n=0`. SUB a=0x0001, b=0x0002 -> `f=0xFFFF`, `c=1`, `n=1`.
- MUL a=0x1234, b=0x0100 -> `out_valid` 17 cycles after accept with `f=0x3400`, `x=0x0012`, `v=1`, and `in_ready=0` throughout.
- DIV a=100, b=7 -> 17 cycles: `f=0x000E`, `x=0x0002`, `e=0`. DIV a=5, b=0 -> 1 cycle: `f=0xFFFF`, `x=0x0005`, `e=1`.
  - Without `ALU_DIV_EN`: both give 1 cycle, `f=0`, `x=0`, `e=1`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid`.
  - During the hold: outputs stable, `in_ready=0`, and `in_valid` pulses are ignored.
  - After `out_ready=1`: the next cycle shows `out_valid=0`, `in_ready=1`.
- Assert `rst` during MUL iteration 5 -> next cycle: IDLE, `in_ready=1`, all outputs 0. A following ADD 2+3 then yields `f=0x0005` after 1 cycle.
